// File: rtl/sram_access_sched.sv
// sram_access_sched: shares one SRAM controller write port between N_REQ
// requesters (round-robin with bounded bursts) and sequences tx_mode
// between write mode and read/transmit mode with a guarded turnaround.
module sram_access_sched #(
  parameter int unsigned N_REQ     = 4,
  parameter int unsigned ADDR_W    = 18,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned BURST_MAX = 4,
  parameter int unsigned TURN_CYC  = 2,
  localparam int unsigned ID_W     = $clog2(N_REQ)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req_valid,
  output logic [N_REQ-1:0]           req_ready,
  input  logic [N_REQ*ADDR_W-1:0]    req_addr,
  input  logic [N_REQ*DATA_W-1:0]    req_data,
  input  logic                       rd_mode_req,
  output logic                       tx_mode,
  output logic                       wr_valid,
  input  logic                       wr_ready,
  output logic [ADDR_W-1:0]          wr_addr,
  output logic [DATA_W-1:0]          wr_data,
  output logic [ID_W-1:0]            grant_id
);

  localparam int unsigned BC_W = $clog2(BURST_MAX + 1);
  localparam int unsigned TC_W = $clog2(TURN_CYC + 1);

  typedef enum logic [1:0] {
    ST_WRITE,
    ST_TURN,
    ST_READ
  } state_e;

  state_e            state_q, state_d;
  logic              to_read_q, to_read_d;
  logic [TC_W-1:0]   turn_cnt_q, turn_cnt_d;
  logic [ID_W-1:0]   owner_q, owner_d;
  logic [BC_W-1:0]   burst_q, burst_d;
  logic              wr_valid_q, wr_valid_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic [ID_W-1:0]   grant_q, grant_d;
  logic              tx_mode_q, tx_mode_d;

  logic              keep_owner;
  logic              sel_valid;
  logic [ID_W-1:0]   sel_idx;
  logic [ID_W-1:0]   cand;
  logic              slot_free;
  logic              accept;

  // Requester selection: sticky owner within its burst budget, else
  // first valid requester scanning upward from owner+1 (owner itself last).
  // burst_q==0 only after reset and means "no owner yet", so requester 0
  // gets first priority even though owner_q resets to N_REQ-1.
  always_comb begin
    sel_valid  = 1'b0;
    sel_idx    = '0;
    cand       = '0;
    keep_owner = (burst_q != '0) && req_valid[owner_q] &&
                 (burst_q < BC_W'(BURST_MAX));
    if (keep_owner) begin
      sel_valid = 1'b1;
      sel_idx   = owner_q;
    end else begin
      // Walk offsets N_REQ..1 so the smallest offset wins last.
      for (int unsigned i = 0; i < N_REQ; i++) begin
        cand = ID_W'((int'(owner_q) + N_REQ - i) % N_REQ);
        if (req_valid[cand]) begin
          sel_valid = 1'b1;
          sel_idx   = cand;
        end
      end
    end
  end

  // Accept when the output slot is free in write mode and no read is pending.
  always_comb begin
    slot_free = ~rst & (state_q == ST_WRITE) & ~rd_mode_req &
                (~wr_valid_q | wr_ready);
    accept    = slot_free & sel_valid;
    req_ready = accept ? ({{(N_REQ-1){1'b0}}, 1'b1} << sel_idx) : '0;
  end

  // Next-state logic for the mode FSM and the write-beat datapath.
  always_comb begin
    state_d    = state_q;
    to_read_d  = to_read_q;
    turn_cnt_d = turn_cnt_q;
    owner_d    = owner_q;
    burst_d    = burst_q;
    wr_valid_d = wr_valid_q;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    grant_d    = grant_q;

    unique case (state_q)
      ST_WRITE: begin
        if (rd_mode_req && (!wr_valid_q || wr_ready)) begin
          state_d    = ST_TURN;
          to_read_d  = 1'b1;
          turn_cnt_d = TC_W'(TURN_CYC);
        end
      end
      ST_TURN: begin
        // Counter loaded with TURN_CYC; leaving as it reaches 0 keeps
        // exactly TURN_CYC cycles in TURN.
        turn_cnt_d = turn_cnt_q - TC_W'(1);
        if (turn_cnt_q <= TC_W'(1)) begin
          state_d = (to_read_q && rd_mode_req) ? ST_READ : ST_WRITE;
        end
      end
      ST_READ: begin
        if (!rd_mode_req) begin
          state_d    = ST_TURN;
          to_read_d  = 1'b0;
          turn_cnt_d = TC_W'(TURN_CYC);
        end
      end
      default: state_d = ST_WRITE;
    endcase

    if (accept) begin
      wr_valid_d = 1'b1;
      wr_addr_d  = req_addr[sel_idx*ADDR_W +: ADDR_W];
      wr_data_d  = req_data[sel_idx*DATA_W +: DATA_W];
      grant_d    = sel_idx;
      owner_d    = sel_idx;
      if (sel_idx != owner_q) begin
        burst_d = BC_W'(1);
      end else if (burst_q < BC_W'(BURST_MAX)) begin
        burst_d = burst_q + BC_W'(1);
      end
    end else if (wr_ready) begin
      wr_valid_d = 1'b0;
    end

    tx_mode_d = (state_d == ST_READ);
  end

  // State and registered outputs with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_WRITE;
      to_read_q  <= 1'b0;
      turn_cnt_q <= '0;
      owner_q    <= ID_W'(N_REQ - 1);
      burst_q    <= '0;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      grant_q    <= '0;
      tx_mode_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      to_read_q  <= to_read_d;
      turn_cnt_q <= turn_cnt_d;
      owner_q    <= owner_d;
      burst_q    <= burst_d;
      wr_valid_q <= wr_valid_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      grant_q    <= grant_d;
      tx_mode_q  <= tx_mode_d;
    end
  end

  assign tx_mode  = tx_mode_q;
  assign wr_valid = wr_valid_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign grant_id = grant_q;

endmodule

// File: tb/tb_sram_access_sched.sv
// Directed testbench for sram_access_sched (N_REQ=4, BURST_MAX=2, TURN_CYC=2).
module tb_sram_access_sched;

  localparam int unsigned N_REQ     = 4;
  localparam int unsigned ADDR_W    = 18;
  localparam int unsigned DATA_W    = 32;
  localparam int unsigned BURST_MAX = 2;
  localparam int unsigned TURN_CYC  = 2;
  localparam int unsigned ID_W      = 2;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ-1:0]        req_ready;
  logic [N_REQ*ADDR_W-1:0] req_addr;
  logic [N_REQ*DATA_W-1:0] req_data;
  logic                    rd_mode_req;
  logic                    tx_mode;
  logic                    wr_valid;
  logic                    wr_ready;
  logic [ADDR_W-1:0]       wr_addr;
  logic [DATA_W-1:0]       wr_data;
  logic [ID_W-1:0]         grant_id;

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  always #5 clk = ~clk;

  sram_access_sched #(
    .N_REQ    (N_REQ),
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .BURST_MAX(BURST_MAX),
    .TURN_CYC (TURN_CYC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_data   (req_data),
    .rd_mode_req(rd_mode_req),
    .tx_mode    (tx_mode),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .grant_id   (grant_id)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    req_addr[i*ADDR_W +: ADDR_W] = a;
    req_data[i*DATA_W +: DATA_W] = d;
  endtask

  task automatic test_reset;
    rst = 1'b1; req_valid = '1; rd_mode_req = 1'b1; wr_ready = 1'b1;
    req_addr = '1; req_data = '1;
    #1;
    n_total++; if (req_ready !== 4'b0000) $display("FAIL reset_ready_c0: got %b want 0000", req_ready); else n_pass++;
    tick;
    n_total++; if (req_ready !== 4'b0000) $display("FAIL reset_ready_c1: got %b want 0000", req_ready); else n_pass++;
    n_total++; if (tx_mode !== 1'b0) $display("FAIL reset_tx_mode: got %b want 0", tx_mode); else n_pass++;
    n_total++; if (wr_valid !== 1'b0) $display("FAIL reset_wr_valid: got %b want 0", wr_valid); else n_pass++;
    n_total++; if (wr_addr !== 18'h0) $display("FAIL reset_wr_addr: got %h want 0", wr_addr); else n_pass++;
    n_total++; if (wr_data !== 32'h0) $display("FAIL reset_wr_data: got %h want 0", wr_data); else n_pass++;
    n_total++; if (grant_id !== 2'd0) $display("FAIL reset_grant_id: got %0d want 0", grant_id); else n_pass++;
    tick;
    n_total++; if (req_ready !== 4'b0000) $display("FAIL reset_ready_c2: got %b want 0000", req_ready); else n_pass++;
    rst = 1'b0; req_valid = '0; rd_mode_req = 1'b0; wr_ready = 1'b1;
    tick;
    n_total++; if (tx_mode !== 1'b0) $display("FAIL post_reset_tx_mode: got %b want 0", tx_mode); else n_pass++;
    n_total++; if (wr_valid !== 1'b0) $display("FAIL post_reset_wr_valid: got %b want 0", wr_valid); else n_pass++;
  endtask

  task automatic test_single;
    set_req(2, 18'h00010, 32'hA5A5A5A5);
    req_valid = 4'b0100; wr_ready = 1'b1;
    #1;
    n_total++; if (req_ready !== 4'b0100) $display("FAIL single_ready: got %b want 0100", req_ready); else n_pass++;
    tick;
    req_valid = '0;
    #1;
    n_total++; if (wr_valid !== 1'b1) $display("FAIL single_wr_valid: got %b want 1", wr_valid); else n_pass++;
    n_total++; if (wr_addr !== 18'h00010) $display("FAIL single_wr_addr: got %h want 00010", wr_addr); else n_pass++;
    n_total++; if (wr_data !== 32'hA5A5A5A5) $display("FAIL single_wr_data: got %h want a5a5a5a5", wr_data); else n_pass++;
    n_total++; if (grant_id !== 2'd2) $display("FAIL single_grant: got %0d want 2", grant_id); else n_pass++;
    tick;
    n_total++; if (wr_valid !== 1'b0) $display("FAIL single_done: got %b want 0", wr_valid); else n_pass++;
  endtask

  task automatic test_round_robin;
    int exp_seq[10] = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0};
    rst = 1'b1;
    tick;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) set_req(i, 18'(32'h100 + i), 32'hD0000000 + i);
    req_valid = 4'hF; wr_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      #1;
      n_total++;
      if (req_ready !== 4'(1 << exp_seq[k])) $display("FAIL rr_ready[%0d]: got %b want %b", k, req_ready, 4'(1 << exp_seq[k]));
      else n_pass++;
      if (k > 0) begin
        n_total++; if (wr_valid !== 1'b1) $display("FAIL rr_wr_valid[%0d]: got %b want 1", k, wr_valid); else n_pass++;
        n_total++;
        if (grant_id !== 2'(exp_seq[k-1])) $display("FAIL rr_grant[%0d]: got %0d want %0d", k, grant_id, exp_seq[k-1]);
        else n_pass++;
        n_total++;
        if (wr_addr !== 18'(32'h100 + exp_seq[k-1])) $display("FAIL rr_addr[%0d]: got %h want %h", k, wr_addr, 18'(32'h100 + exp_seq[k-1]));
        else n_pass++;
      end
      tick;
    end
    req_valid = '0;
    #1;
    n_total++; if (grant_id !== 2'd0) $display("FAIL rr_last_grant: got %0d want 0", grant_id); else n_pass++;
    n_total++; if (wr_valid !== 1'b1) $display("FAIL rr_last_valid: got %b want 1", wr_valid); else n_pass++;
    tick;
    n_total++; if (wr_valid !== 1'b0) $display("FAIL rr_drain: got %b want 0", wr_valid); else n_pass++;
  endtask

  task automatic test_stall;
    set_req(1, 18'h2AAAA, 32'h12345678);
    set_req(3, 18'h3C3C3, 32'hCAFEF00D);
    req_valid = 4'b0010; wr_ready = 1'b1;
    #1;
    n_total++; if (req_ready !== 4'b0010) $display("FAIL stall_accept: got %b want 0010", req_ready); else n_pass++;
    tick;
    req_valid = 4'b1000; wr_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      n_total++; if (wr_valid !== 1'b1) $display("FAIL stall_valid[%0d]: got %b want 1", k, wr_valid); else n_pass++;
      n_total++; if (wr_addr !== 18'h2AAAA) $display("FAIL stall_addr[%0d]: got %h want 2aaaa", k, wr_addr); else n_pass++;
      n_total++; if (wr_data !== 32'h12345678) $display("FAIL stall_data[%0d]: got %h want 12345678", k, wr_data); else n_pass++;
      n_total++; if (grant_id !== 2'd1) $display("FAIL stall_grant[%0d]: got %0d want 1", k, grant_id); else n_pass++;
      n_total++; if (req_ready !== 4'b0000) $display("FAIL stall_ready[%0d]: got %b want 0000", k, req_ready); else n_pass++;
      tick;
    end
    wr_ready = 1'b1;
    #1;
    n_total++; if (wr_valid !== 1'b1) $display("FAIL stall_release_valid: got %b want 1", wr_valid); else n_pass++;
    n_total++; if (req_ready !== 4'b1000) $display("FAIL stall_release_ready: got %b want 1000", req_ready); else n_pass++;
    tick;
    req_valid = '0;
    #1;
    n_total++; if (wr_valid !== 1'b1) $display("FAIL stall_next_valid: got %b want 1", wr_valid); else n_pass++;
    n_total++; if (grant_id !== 2'd3) $display("FAIL stall_next_grant: got %0d want 3", grant_id); else n_pass++;
    n_total++; if (wr_data !== 32'hCAFEF00D) $display("FAIL stall_next_data: got %h want cafef00d", wr_data); else n_pass++;
    tick;
    n_total++; if (wr_valid !== 1'b0) $display("FAIL stall_drain: got %b want 0", wr_valid); else n_pass++;
  endtask

  task automatic test_mode_switch;
    logic exp_tx[4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    set_req(0, 18'h00ABC, 32'h0F0F0F0F);
    req_valid = 4'b0001; wr_ready = 1'b1; rd_mode_req = 1'b0;
    #1;
    n_total++; if (req_ready !== 4'b0001) $display("FAIL ms_accept: got %b want 0001", req_ready); else n_pass++;
    tick;
    set_req(2, 18'h00222, 32'h22222222);
    req_valid = 4'b0100; wr_ready = 1'b0; rd_mode_req = 1'b1;
    #1;
    n_total++; if (wr_valid !== 1'b1) $display("FAIL ms_stall_valid: got %b want 1", wr_valid); else n_pass++;
    n_total++; if (grant_id !== 2'd0) $display("FAIL ms_stall_grant: got %0d want 0", grant_id); else n_pass++;
    n_total++; if (req_ready !== 4'b0000) $display("FAIL ms_stall_ready: got %b want 0000", req_ready); else n_pass++;
    tick;
    n_total++; if (wr_valid !== 1'b1) $display("FAIL ms_stall2_valid: got %b want 1", wr_valid); else n_pass++;
    n_total++; if (tx_mode !== 1'b0) $display("FAIL ms_stall2_tx: got %b want 0", tx_mode); else n_pass++;
    tick;
    wr_ready = 1'b1;
    #1;
    n_total++; if (wr_valid !== 1'b1) $display("FAIL ms_hs_valid: got %b want 1", wr_valid); else n_pass++;
    n_total++; if (req_ready !== 4'b0000) $display("FAIL ms_hs_ready: got %b want 0000", req_ready); else n_pass++;
    for (int k = 0; k < 4; k++) begin
      tick;
      n_total++; if (tx_mode !== exp_tx[k]) $display("FAIL ms_tx[%0d]: got %b want %b", k, tx_mode, exp_tx[k]); else n_pass++;
      n_total++; if (req_ready !== 4'b0000) $display("FAIL ms_ready[%0d]: got %b want 0000", k, req_ready); else n_pass++;
      n_total++; if (wr_valid !== 1'b0) $display("FAIL ms_valid[%0d]: got %b want 0", k, wr_valid); else n_pass++;
    end
    rd_mode_req = 1'b0;
    tick;
    n_total++; if (tx_mode !== 1'b0) $display("FAIL ms_fall_tx: got %b want 0", tx_mode); else n_pass++;
    n_total++; if (req_ready !== 4'b0000) $display("FAIL ms_fall_ready1: got %b want 0000", req_ready); else n_pass++;
    tick;
    n_total++; if (req_ready !== 4'b0000) $display("FAIL ms_fall_ready2: got %b want 0000", req_ready); else n_pass++;
    tick;
    n_total++; if (req_ready !== 4'b0100) $display("FAIL ms_first_accept: got %b want 0100", req_ready); else n_pass++;
    tick;
    req_valid = '0;
    #1;
    n_total++; if (wr_valid !== 1'b1) $display("FAIL ms_beat_valid: got %b want 1", wr_valid); else n_pass++;
    n_total++; if (grant_id !== 2'd2) $display("FAIL ms_beat_grant: got %0d want 2", grant_id); else n_pass++;
    n_total++; if (wr_data !== 32'h22222222) $display("FAIL ms_beat_data: got %h want 22222222", wr_data); else n_pass++;
    tick;
    n_total++; if (wr_valid !== 1'b0) $display("FAIL ms_drain: got %b want 0", wr_valid); else n_pass++;
  endtask

  task automatic test_abort;
    rd_mode_req = 1'b1; req_valid = '0;
    #1;
    n_total++; if (tx_mode !== 1'b0) $display("FAIL ab_p0_tx: got %b want 0", tx_mode); else n_pass++;
    tick;
    rd_mode_req = 1'b0;
    set_req(0, 18'h0ABCD, 32'h5555AAAA);
    req_valid = 4'b0001;
    #1;
    n_total++; if (tx_mode !== 1'b0) $display("FAIL ab_p1_tx: got %b want 0", tx_mode); else n_pass++;
    n_total++; if (req_ready !== 4'b0000) $display("FAIL ab_p1_ready: got %b want 0000", req_ready); else n_pass++;
    tick;
    n_total++; if (tx_mode !== 1'b0) $display("FAIL ab_p2_tx: got %b want 0", tx_mode); else n_pass++;
    n_total++; if (req_ready !== 4'b0000) $display("FAIL ab_p2_ready: got %b want 0000", req_ready); else n_pass++;
    tick;
    n_total++; if (tx_mode !== 1'b0) $display("FAIL ab_p3_tx: got %b want 0", tx_mode); else n_pass++;
    n_total++; if (req_ready !== 4'b0001) $display("FAIL ab_p3_ready: got %b want 0001", req_ready); else n_pass++;
    tick;
    req_valid = '0;
    #1;
    n_total++; if (wr_valid !== 1'b1) $display("FAIL ab_beat_valid: got %b want 1", wr_valid); else n_pass++;
    n_total++; if (wr_addr !== 18'h0ABCD) $display("FAIL ab_beat_addr: got %h want 0abcd", wr_addr); else n_pass++;
    tick;
    n_total++; if (wr_valid !== 1'b0) $display("FAIL ab_drain: got %b want 0", wr_valid); else n_pass++;
  endtask

  task automatic test_reset_mid;
    rd_mode_req = 1'b1;
    tick;
    tick;
    tick;
    n_total++; if (tx_mode !== 1'b1) $display("FAIL rm_read_tx: got %b want 1", tx_mode); else n_pass++;
    rst = 1'b1;
    tick;
    n_total++; if (tx_mode !== 1'b0) $display("FAIL rm_reset_tx: got %b want 0", tx_mode); else n_pass++;
    n_total++; if (req_ready !== 4'b0000) $display("FAIL rm_reset_ready: got %b want 0000", req_ready); else n_pass++;
    rst = 1'b0; rd_mode_req = 1'b0;
    tick;
    n_total++; if (tx_mode !== 1'b0) $display("FAIL rm_after_tx: got %b want 0", tx_mode); else n_pass++;
    set_req(0, 18'h11111, 32'h77777777);
    req_valid = 4'b0001; wr_ready = 1'b0;
    #1;
    n_total++; if (req_ready !== 4'b0001) $display("FAIL rb_accept: got %b want 0001", req_ready); else n_pass++;
    tick;
    req_valid = '0; rst = 1'b1;
    #1;
    n_total++; if (wr_valid !== 1'b1) $display("FAIL rb_pending: got %b want 1", wr_valid); else n_pass++;
    tick;
    n_total++; if (wr_valid !== 1'b0) $display("FAIL rb_dropped_valid: got %b want 0", wr_valid); else n_pass++;
    n_total++; if (wr_addr !== 18'h0) $display("FAIL rb_dropped_addr: got %h want 0", wr_addr); else n_pass++;
    rst = 1'b0; wr_ready = 1'b1;
    tick;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish by time %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; req_valid = '0; req_addr = '0; req_data = '0;
    rd_mode_req = 1'b0; wr_ready = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_stall();
    test_mode_switch();
    test_abort();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
